// File: rtl/arith_pkg.sv
// Shared definitions for the small arithmetic units (muladd, div):
// operand/result widths, iteration count and the common control states.
package arith_pkg;

    localparam int OPW   = 4;   // operand width
    localparam int RESW  = 8;   // result width
    localparam int STEPS = 4;   // shift/add iterations per operation

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : arith_pkg

// File: rtl/muladd.sv
// Sequential shift-and-add multiplier with addend: ry = a * b + c.
// Always takes exactly STEPS iterations after the load edge (no early exit).
// Rebuilds a dividend from the quotient, divisor and remainder produced by div.
module muladd
    import arith_pkg::*;
(
    input  logic             clk,
    input  logic             rst,    // asynchronous, active-low
    input  logic             ld,
    input  logic [OPW-1:0]   a,
    input  logic [OPW-1:0]   b,
    input  logic [OPW-1:0]   c,
    output logic [RESW-1:0]  ra,
    output logic [OPW-1:0]   rb,
    output logic [RESW-1:0]  ry,
    output logic             busy,
    output logic             done
);

    localparam logic [1:0] LAST_STEP = 2'(STEPS - 1);

    state_t            state_reg;
    logic [1:0]        cnt_reg;
    logic [RESW-1:0]   ra_reg;
    logic [OPW-1:0]    rb_reg;
    logic [RESW-1:0]   ry_reg;

    // Control: state and step counter; a load restarts from any state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= IDLE;
            cnt_reg   <= 2'd0;
        end else if (ld) begin
            state_reg <= BUSY;
            cnt_reg   <= 2'd0;
        end else begin
            case (state_reg)
                BUSY: begin
                    cnt_reg <= cnt_reg + 2'd1;
                    if (cnt_reg == LAST_STEP) begin
                        state_reg <= DONE;
                    end
                end
                default: begin
                    // IDLE and DONE hold until the next load
                end
            endcase
        end
    end

    // Datapath: load operands, then conditionally add and shift once per BUSY cycle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ra_reg <= '0;
            rb_reg <= '0;
            ry_reg <= '0;
        end else if (ld) begin
            ra_reg <= {{(RESW-OPW){1'b0}}, a};
            rb_reg <= b;
            ry_reg <= {{(RESW-OPW){1'b0}}, c};
        end else if (state_reg == BUSY) begin
            // 15*15+15 = 240 fits in RESW bits, so no carry-out is kept
            if (rb_reg[0]) begin
                ry_reg <= ry_reg + ra_reg;
            end
            ra_reg <= {ra_reg[RESW-2:0], 1'b0};
            rb_reg <= {1'b0, rb_reg[OPW-1:1]};
        end
    end

    assign ra   = ra_reg;
    assign rb   = rb_reg;
    assign ry   = ry_reg;
    // Status flags decode the state register only; no path from ld.
    assign busy = (state_reg == BUSY);
    assign done = (state_reg == DONE);

endmodule : muladd

// File: tb/tb_muladd.sv
// Self-checking bench for muladd: expected results are queued when an
// operation is loaded and compared when done is observed.
module tb_muladd;

    logic       clk;
    logic       rst;
    logic       ld;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] c;
    logic [7:0] ra;
    logic [3:0] rb;
    logic [7:0] ry;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_bad    = 0;

    logic [7:0] exp_q[$];

    muladd dut (
        .clk  (clk),
        .rst  (rst),
        .ld   (ld),
        .a    (a),
        .b    (b),
        .c    (c),
        .ra   (ra),
        .rb   (rb),
        .ry   (ry),
        .busy (busy),
        .done (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] expv);
        n_checks++;
        if (got !== expv) begin
            n_bad++;
            $display("FAIL %s: got=%0d (0x%02h) expected=%0d (0x%02h)", tag, got, got, expv, expv);
        end
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ra"},   ra, 8'd0);
        check({tag, "_rb"},   {4'd0, rb}, 8'd0);
        check({tag, "_ry"},   ry, 8'd0);
        check({tag, "_busy"}, {7'd0, busy}, 8'd0);
        check({tag, "_done"}, {7'd0, done}, 8'd0);
    endtask

    // Drive a load on the next negedge; leaves time at the negedge after the load edge.
    task automatic start_op(input logic [3:0] ta, input logic [3:0] tb_v, input logic [3:0] tc,
                            input logic [7:0] expv);
        @(negedge clk);
        a  = ta;
        b  = tb_v;
        c  = tc;
        ld = 1'b1;
        exp_q.push_back(expv);
        @(negedge clk);
        ld = 1'b0;
        check("busy_after_ld", {7'd0, busy}, 8'd1);
        check("ry_after_ld", ry, {4'd0, tc});
    endtask

    // Wait (bounded) for done, check latency and pop the scoreboard entry.
    task automatic finish_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                             input logic [3:0] tc, input int cycles_so_far);
        int n;
        logic [7:0] expv;
        n = cycles_so_far;
        while (!done && n < 12) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_latency"}, 8'(n), 8'd4);
        check({tag, "_done"}, {7'd0, done}, 8'd1);
        check({tag, "_busy"}, {7'd0, busy}, 8'd0);
        if (exp_q.size() == 0) begin
            check({tag, "_sb_empty"}, 8'd0, 8'd1);
        end else begin
            expv = exp_q.pop_front();
            check({tag, "_ry"}, ry, expv);
        end
        check({tag, "_ra"}, ra, {ta, 4'd0});
        check({tag, "_rb"}, {4'd0, rb}, 8'd0);
        $display("op %s: a=%0d b=%0d c=%0d ry=%0d cycles=%0d", tag, ta, tb_v, tc, ry, n);
    endtask

    task automatic run_op(input string tag, input logic [3:0] ta, input logic [3:0] tb_v,
                          input logic [3:0] tc, input logic [7:0] expv);
        start_op(ta, tb_v, tc, expv);
        finish_op(tag, ta, tb_v, tc, 0);
    endtask

    initial begin
        logic [3:0] q4;
        logic [3:0] r4;
        int n;

        rst = 1'b0;
        ld  = 1'b0;
        a   = '0;
        b   = '0;
        c   = '0;

        // Reset held with random activity on the inputs
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            ld = 1'($urandom);
            a  = 4'($urandom);
            b  = 4'($urandom);
            c  = 4'($urandom);
            #1;
            check_zero("rst_hold");
        end
        @(negedge clk);
        ld  = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check_zero("post_rst");
        end
        $display("reset: outputs zero during and after reset");

        // Basic, maximum and zero cases
        run_op("basic", 4'd13, 4'd11, 4'd0, 8'd143);
        run_op("max",   4'd15, 4'd15, 4'd15, 8'd240);
        run_op("b_zero", 4'd5, 4'd0, 4'd7, 8'd7);
        run_op("a_zero", 4'd0, 4'd9, 4'd3, 8'd3);

        // Restart in the second BUSY cycle; first result must never surface
        start_op(4'd6, 4'd7, 4'd0, 8'd42);
        void'(exp_q.pop_back());
        @(negedge clk);
        a  = 4'd3;
        b  = 4'd4;
        c  = 4'd1;
        ld = 1'b1;
        exp_q.push_back(8'd13);
        @(negedge clk);
        ld = 1'b0;
        check("restart_busy", {7'd0, busy}, 8'd1);
        check("restart_ry_init", ry, 8'd1);
        n = 0;
        for (int i = 0; i < 3; i++) begin
            check("restart_no_early_done", {7'd0, done}, 8'd0);
            @(negedge clk);
            n++;
        end
        finish_op("restart", 4'd3, 4'd4, 4'd1, n);

        // Asynchronous reset between edges in the second BUSY cycle
        start_op(4'd9, 4'd9, 4'd9, 8'd90);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_zero("async_rst");
        void'(exp_q.pop_back());
        @(negedge clk);
        check_zero("async_rst_held");
        rst = 1'b1;
        @(negedge clk);
        check_zero("async_rst_idle");
        run_op("after_rst", 4'd7, 4'd6, 4'd5, 8'd47);

        // DONE holds for ten idle cycles
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check("hold_ry", ry, 8'd47);
            check("hold_done", {7'd0, done}, 8'd1);
        end

        // Round trip against the restoring divider: muladd(q, b, r) == a
        for (int ai = 0; ai < 16; ai++) begin
            for (int bi = 1; bi < 16; bi++) begin
                q4 = 4'(ai / bi);
                r4 = 4'(ai % bi);
                run_op("roundtrip", q4, 4'(bi), r4, 8'(ai));
            end
        end

        if (exp_q.size() != 0) begin
            check("sb_leftover", 8'(exp_q.size()), 8'd0);
        end

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

    // Global watchdog so the run always terminates
    initial begin
        #2000000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_muladd
